// File: rtl/demux_1x4_buf.sv
// Buffered 1-to-4 demultiplexer: one-entry holding register per lane, valid/ready on every side.
// Optional macro DEMUX_RR_EN replaces D_select with an internal round-robin lane pointer.
module demux_1x4_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D_in,
  input  logic             D_valid,
  output logic             D_ready,
  input  logic [1:0]       D_select,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [3:0]       Y_valid,
  input  logic [3:0]       Y_ready,
  output logic [7:0]       W_count
);

  logic [WIDTH-1:0] r_y [4];
  logic [3:0]       r_vld;
  logic [7:0]       r_cnt;
  logic [1:0]       w_tgt;
  logic             w_ready;
  logic             w_accept;
  logic [3:0]       w_load;
  logic [3:0]       w_vld_nxt;

`ifdef DEMUX_RR_EN
  logic [1:0] r_ptr;

  // The pointer only moves on an accept, so a stalled producer keeps waiting on the same lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end
  end

  assign w_tgt = r_ptr;
`else
  assign w_tgt = D_select;
`endif

  // A full lane can still take a word when its consumer drains it on the same edge.
  assign w_ready   = !reset && (!r_vld[w_tgt] || Y_ready[w_tgt]);
  assign w_accept  = D_valid && w_ready;
  assign w_load    = w_accept ? (4'b0001 << w_tgt) : 4'b0000;
  assign w_vld_nxt = (r_vld & ~Y_ready) | w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        r_y[n] <= '0;
      end
      r_vld <= 4'b0000;
      r_cnt <= 8'd0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_accept) begin
        r_y[w_tgt] <= D_in;
        r_cnt      <= r_cnt + 8'd1;
      end
    end
  end

  assign D_ready = w_ready;
  assign Y0      = r_y[0];
  assign Y1      = r_y[1];
  assign Y2      = r_y[2];
  assign Y3      = r_y[3];
  assign Y_valid = r_vld;
  assign W_count = r_cnt;

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Directed bench for demux_1x4_buf: reset, steering, pass-through, drain, counter wrap and,
// when DEMUX_RR_EN is defined, round-robin lane order and stalling.
module tb_demux_1x4_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D_in;
  logic       D_valid;
  logic       D_ready;
  logic [1:0] D_select;
  logic [3:0] Y0, Y1, Y2, Y3;
  logic [3:0] Y_valid;
  logic [3:0] Y_ready;
  logic [7:0] W_count;

  int checks   = 0;
  int failures = 0;

  demux_1x4_buf #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .D_in    (D_in),
    .D_valid (D_valid),
    .D_ready (D_ready),
    .D_select(D_select),
    .Y0      (Y0),
    .Y1      (Y1),
    .Y2      (Y2),
    .Y3      (Y3),
    .Y_valid (Y_valid),
    .Y_ready (Y_ready),
    .W_count (W_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic       dv;
    logic [1:0] sel;
    logic [3:0] yr;
    logic       exp_rdy;
    logic [3:0] exp_vld;
    logic [3:0] e0, e1, e2, e3;
    logic [7:0] ecnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [3:0] lane(input int n);
    case (n)
      0:       return Y0;
      1:       return Y1;
      2:       return Y2;
      default: return Y3;
    endcase
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    D_valid = 1'b0;
    Y_ready = 4'b0000;
    D_select = 2'd0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

`ifndef DEMUX_RR_EN
  vec_t tbl [13];
`endif

  initial begin
    reset    = 1'b1;
    D_in     = 4'h0;
    D_valid  = 1'b0;
    D_select = 2'd0;
    Y_ready  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", Y_valid, 4'b0000);
    chk("rst_cnt", W_count, 8'd0);
    chk("rst_rdy", D_ready, 1'b0);
    chk("rst_y", {Y3, Y2, Y1, Y0}, 16'h0000);
    reset = 1'b0;
    #1 chk("rel_rdy", D_ready, 1'b1);

`ifndef DEMUX_RR_EN
    //              din   dv    sel   yr       rdy   vld      Y0    Y1    Y2    Y3    cnt
    tbl[0]  = '{4'hA, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0001, 4'hA, 4'h0, 4'h0, 4'h0, 8'd1};
    tbl[1]  = '{4'h5, 1'b1, 2'd1, 4'b0000, 1'b1, 4'b0011, 4'hA, 4'h5, 4'h0, 4'h0, 8'd2};
    tbl[2]  = '{4'hC, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0111, 4'hA, 4'h5, 4'hC, 4'h0, 8'd3};
    tbl[3]  = '{4'h3, 1'b1, 2'd3, 4'b0000, 1'b1, 4'b1111, 4'hA, 4'h5, 4'hC, 4'h3, 8'd4};
    tbl[4]  = '{4'h9, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b1111, 4'hA, 4'h5, 4'hC, 4'h3, 8'd4};
    tbl[5]  = '{4'h7, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b1111, 4'hA, 4'h5, 4'h7, 4'h3, 8'd5};
    tbl[6]  = '{4'h0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b1101, 4'hA, 4'h5, 4'h7, 4'h3, 8'd5};
    tbl[7]  = '{4'h0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'b1101, 4'hA, 4'h5, 4'h7, 4'h3, 8'd5};
    tbl[8]  = '{4'h0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b1101, 4'hA, 4'h5, 4'h7, 4'h3, 8'd5};
    tbl[9]  = '{4'h0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 4'hA, 4'h5, 4'h7, 4'h3, 8'd5};
    tbl[10] = '{4'hE, 1'b1, 2'd1, 4'b0000, 1'b1, 4'b0010, 4'hA, 4'hE, 4'h7, 4'h3, 8'd6};
    tbl[11] = '{4'h1, 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0001, 4'h1, 4'hE, 4'h7, 4'h3, 8'd7};
    tbl[12] = '{4'h6, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0101, 4'h1, 4'hE, 4'h6, 4'h3, 8'd8};

    for (int i = 0; i < 13; i++) begin
      D_in     = tbl[i].din;
      D_valid  = tbl[i].dv;
      D_select = tbl[i].sel;
      Y_ready  = tbl[i].yr;
      #1 chk($sformatf("v%0d_rdy", i), D_ready, tbl[i].exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), Y_valid, tbl[i].exp_vld);
      chk($sformatf("v%0d_y", i), {Y3, Y2, Y1, Y0},
          {tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0});
      chk($sformatf("v%0d_cnt", i), W_count, tbl[i].ecnt);
    end

    // Asynchronous reset in the middle of a cycle with lanes 0 and 2 occupied.
    D_valid = 1'b0;
    Y_ready = 4'b0000;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_vld", Y_valid, 4'b0000);
    chk("mid_rst_y", {Y3, Y2, Y1, Y0}, 16'h0000);
    chk("mid_rst_cnt", W_count, 8'd0);
    chk("mid_rst_rdy", D_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    D_select = 2'd0;
    #1 chk("mid_rel_rdy", D_ready, 1'b1);
`else
    // Round-robin: D_select is ignored, consumers always ready.
    D_select = 2'd3;
    Y_ready  = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      D_in    = 4'(i + 1);
      D_valid = 1'b1;
      #1 chk($sformatf("rr%0d_rdy", i), D_ready, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_vld", i), Y_valid, 4'b0001 << (i % 4));
      chk($sformatf("rr%0d_y", i), lane(i % 4), 4'(i + 1));
    end
    // Pointer now at lane 2; hold lane 2 back so it fills and the producer stalls on it.
    Y_ready = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      D_in = 4'(7 + i);
      @(posedge clk);
      #1;
    end
    chk("rr_fill_vld", Y_valid, 4'b0110);
    chk("rr_fill_cnt", W_count, 8'd10);
    D_in = 4'hB;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("rr_stall%0d_rdy", i), D_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("rr_stall_cnt", W_count, 8'd10);
    chk("rr_stall_y2", Y2, 4'h7);
    Y_ready = 4'b1111;
    #1 chk("rr_unstall_rdy", D_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("rr_unstall_y2", Y2, 4'hB);
    chk("rr_unstall_vld", Y_valid, 4'b0100);
    chk("rr_unstall_cnt", W_count, 8'd11);
    pulse_reset();
`endif

    // 257 accepts with every consumer ready: no stall anywhere, counter wraps to 1.
    begin
      int stalls;
      stalls   = 0;
      Y_ready  = 4'b1111;
      D_select = 2'd0;
      D_valid  = 1'b1;
      for (int i = 0; i < 257; i++) begin
        D_in = 4'(i);
        #1 if (!D_ready) stalls++;
        @(posedge clk);
        #1;
        if (i == 255) chk("wrap_cnt0", W_count, 8'd0);
      end
      D_valid = 1'b0;
      chk("wrap_stalls", stalls, 0);
      chk("wrap_cnt1", W_count, 8'd1);
      chk("wrap_vld", Y_valid, 4'b0001);
      chk("wrap_y0", Y0, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
